// File: rtl/exp_approx_pipe_if.sv
// -----------------------------------------------------------------------------
// exp_approx_pipe_if
// Stream bundle for the pipelined e^x unit: the input beat (valid/ready, packed
// lanes, row-end tag) and the output beat (valid/ready, packed results, tag,
// per-lane saturation flags).
//   slave  : the e^x unit's view (consumes in_*, produces out_*)
//   master : the surrounding datapath's view (produces in_*, consumes out_*)
// -----------------------------------------------------------------------------
interface exp_approx_pipe_if #(
  parameter int NUM_LANES = 4,
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16
);
  logic                           in_valid;
  logic                           in_ready;
  logic [NUM_LANES*IN_WIDTH-1:0]  in_x;
  logic                           in_last;
  logic                           out_valid;
  logic                           out_ready;
  logic [NUM_LANES*OUT_WIDTH-1:0] out_e;
  logic                           out_last;
  logic [NUM_LANES-1:0]           out_sat;

  modport slave (
    input  in_valid, in_x, in_last, out_ready,
    output in_ready, out_valid, out_e, out_last, out_sat
  );

  modport master (
    output in_valid, in_x, in_last, out_ready,
    input  in_ready, out_valid, out_e, out_last, out_sat
  );
endinterface

// File: rtl/exp_approx_pipe.sv
// -----------------------------------------------------------------------------
// exp_approx_pipe
// Multi-lane, three-stage pipelined fixed-point e^x for the softmax datapath.
//   e^x = 2^(x*log2e) = 2^z * 2^f, z = floor(x*log2e), f in [0,1)
//   stage 1: y = x * log2e (full-width signed product)
//   stage 2: split y into z and f, look up 2^f in a table built at elaboration
//   stage 3: shift the table value by z, clipping to all-ones on overflow
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, flushes every in-flight beat
//   bus  - exp_approx_pipe_if.slave: in_valid/in_ready/in_x/in_last and
//          out_valid/out_ready/out_e/out_last/out_sat
// All stages advance together when the output register is empty or being
// drained (in_ready = !out_valid || out_ready); bubbles are kept.
// Optional macro EXP_APPROX_LERP_EN: stage 2 linearly interpolates between
// adjacent table entries using the fraction bits below the table index.
// -----------------------------------------------------------------------------
module exp_approx_pipe #(
  parameter int NUM_LANES         = 4,
  parameter int IN_WIDTH          = 16,
  parameter int IN_FRAC           = 8,
  parameter int OUT_WIDTH         = 16,
  parameter int OUT_FRAC          = 14,
  parameter int LUT_ADDRESS_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  exp_approx_pipe_if.slave     bus
);

  localparam int L      = LUT_ADDRESS_WIDTH;
  // Product of a signed IN_WIDTH value and an unsigned 16-bit Q1.15 constant.
  localparam int Y_W    = IN_WIDTH + 17;
  localparam int F_W    = IN_FRAC + 15;
  localparam int Z_W    = Y_W - F_W;
  // Table values lie in [2^OUT_FRAC, 2^(OUT_FRAC+1)].
  localparam int M_W    = OUT_FRAC + 2;
  localparam int W_W    = M_W + OUT_WIDTH;
  localparam int LUT_N  = 1 << L;
  // Fixed-point precision used only while building the table.
  localparam int FB     = 40;
`ifdef EXP_APPROX_LERP_EN
  localparam int LUT_SIZE = LUT_N + 1;
  localparam int R        = ((F_W - L) < 8) ? (F_W - L) : 8;
`else
  localparam int LUT_SIZE = LUT_N;
`endif

  localparam logic signed [16:0]  LOG2E = 17'sd47274;
  localparam logic [Z_W-1:0]      OW_Z  = Z_W'(OUT_WIDTH);

  // Integer square root, bit-serial; used for the table only.
  function automatic logic [127:0] isqrt(input logic [127:0] v);
    logic [127:0] res;
    logic [127:0] rem;
    logic [127:0] bitv;
    res  = 128'd0;
    rem  = v;
    bitv = 128'd1 << 126;
    for (int i = 0; i < 64; i++) begin
      if (rem >= (res + bitv)) begin
        rem = rem - (res + bitv);
        res = (res >> 1) + bitv;
      end else begin
        res = res >> 1;
      end
      bitv = bitv >> 2;
    end
    return res;
  endfunction

  // round(2^(k/2^L) * 2^OUT_FRAC), composed from repeated square roots of 2.
  function automatic logic [M_W-1:0] lut_entry(input int k);
    logic [127:0]   s;
    logic [127:0]   acc;
    logic [M_W-1:0] res;
    res = '0;
    if (k >= LUT_N) begin
      res[OUT_FRAC+1] = 1'b1;
    end else begin
      s   = 128'd2 << FB;
      acc = 128'd1 << FB;
      for (int j = 1; j <= L; j++) begin
        s = isqrt(s << FB);
        if (k[L-j]) begin
          acc = (acc * s) >> FB;
        end
      end
      acc = (acc + (128'd1 << (FB - OUT_FRAC - 1))) >> (FB - OUT_FRAC);
      res = acc[M_W-1:0];
    end
    return res;
  endfunction

  logic [M_W-1:0] lut [LUT_SIZE];

  for (genvar k = 0; k < LUT_SIZE; k++) begin : g_lut
    localparam logic [M_W-1:0] ENTRY = lut_entry(k);
    assign lut[k] = ENTRY;
  end

  logic adv_s;
  logic v1_r, v2_r, v3_r;
  logic l1_r, l2_r, l3_r;

  assign adv_s         = !v3_r || bus.out_ready;
  assign bus.in_ready  = adv_s;
  assign bus.out_valid = v3_r;
  assign bus.out_last  = l3_r;

  // Stage valids and row-end tags; everything shifts together on adv.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r <= 1'b0;
      v2_r <= 1'b0;
      v3_r <= 1'b0;
      l1_r <= 1'b0;
      l2_r <= 1'b0;
      l3_r <= 1'b0;
    end else if (adv_s) begin
      v1_r <= bus.in_valid;
      l1_r <= bus.in_valid & bus.in_last;
      v2_r <= v1_r;
      l2_r <= l1_r;
      v3_r <= v2_r;
      l3_r <= l2_r;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic signed [IN_WIDTH-1:0] x_s;
    logic signed [Y_W-1:0]      y_s;
    logic signed [Y_W-1:0]      y_r;
    logic signed [Z_W-1:0]      z_s;
    logic signed [Z_W-1:0]      z_r;
    logic [L-1:0]               idx_s;
    logic [M_W-1:0]             m_s;
    logic [M_W-1:0]             m_r;
    logic [OUT_WIDTH-1:0]       e_s;
    logic [OUT_WIDTH-1:0]       e_r;
    logic                       sat_s;
    logic                       sat_r;
    logic [Z_W-1:0]             zmag_s;
    logic [W_W-1:0]             wide_s;
    logic                       unused_frac;

    assign x_s = bus.in_x[i*IN_WIDTH +: IN_WIDTH];
    assign y_s = Y_W'(x_s) * Y_W'(LOG2E);

    // Taking the integer part by slicing is an arithmetic floor, so negative
    // y gets z rounded toward -inf and a non-negative fraction.
    assign z_s   = y_r[Y_W-1:F_W];
    assign idx_s = y_r[F_W-1 -: L];
    assign unused_frac = ^y_r[F_W-L-1:0];

`ifdef EXP_APPROX_LERP_EN
    logic [L:0]       idx_n_s;
    logic [M_W-1:0]   lo_s;
    logic [M_W-1:0]   hi_s;
    logic [M_W-1:0]   diff_s;
    logic [R-1:0]     r_s;
    logic [M_W+R-1:0] prod_s;

    assign idx_n_s = {1'b0, idx_s} + {{L{1'b0}}, 1'b1};
    assign lo_s    = lut[{1'b0, idx_s}];
    assign hi_s    = lut[idx_n_s];
    assign diff_s  = hi_s - lo_s;
    assign r_s     = y_r[F_W-L-1 -: R];
    assign prod_s  = (M_W+R)'(diff_s) * (M_W+R)'(r_s);
    assign m_s     = lo_s + M_W'(prod_s >> R);
`else
    assign m_s = lut[idx_s];
`endif

    // Stage 3: scale 2^f by 2^z, flushing to zero or clipping to all-ones.
    always_comb begin
      e_s    = '0;
      sat_s  = 1'b0;
      zmag_s = '0;
      wide_s = '0;
      if (z_r[Z_W-1]) begin
        zmag_s = -z_r;
        if (zmag_s >= OW_Z) begin
          e_s = '0;
        end else begin
          e_s = OUT_WIDTH'(m_r >> zmag_s);
        end
      end else begin
        zmag_s = z_r;
        if (zmag_s >= OW_Z) begin
          e_s   = '1;
          sat_s = 1'b1;
        end else begin
          wide_s = W_W'(m_r) << zmag_s;
          if (|wide_s[W_W-1:OUT_WIDTH]) begin
            e_s   = '1;
            sat_s = 1'b1;
          end else begin
            e_s = wide_s[OUT_WIDTH-1:0];
          end
        end
      end
    end

    // Per-lane datapath registers for all three stages.
    always_ff @(posedge clk) begin
      if (rst) begin
        y_r   <= '0;
        z_r   <= '0;
        m_r   <= '0;
        e_r   <= '0;
        sat_r <= 1'b0;
      end else if (adv_s) begin
        y_r   <= y_s;
        z_r   <= z_s;
        m_r   <= m_s;
        e_r   <= e_s;
        sat_r <= sat_s;
      end
    end

    assign bus.out_e[i*OUT_WIDTH +: OUT_WIDTH] = e_r;
    assign bus.out_sat[i]                      = sat_r;
  end

endmodule

// File: tb/tb_exp_approx_pipe.sv
// -----------------------------------------------------------------------------
// tb_exp_approx_pipe
// Scoreboard bench for exp_approx_pipe (default build, no interpolation).
// Stimulus pushes the hand-computed response into a queue; a monitor on the
// falling edge compares whatever the unit presents against the queue head,
// and checks accept-to-output latency where the stimulus asks for it.
// -----------------------------------------------------------------------------
module tb_exp_approx_pipe;
  localparam int NL = 4;
  localparam int IW = 16;
  localparam int OW = 16;
  localparam int NV = 14;

  typedef struct {
    logic [NL*OW-1:0] e;
    logic [NL-1:0]    sat;
    logic             last;
    int               cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  exp_t q [$];
  exp_t mon_it;

  // Directed vectors: input (Q8.8) -> e^x (Q2.14), saturation flag.
  int          tx [NV] = '{0, -256, 256, 512, -32768, 128, -128, -2048,
                           384, 320, -1, 1, 32767, -2750};
  logic [15:0] te [NV] = '{16'd16384, 16'd5792, 16'd44376, 16'd65535, 16'd0,
                           16'd26386, 16'd9742, 16'd5, 16'd65535, 16'd55108,
                           16'd15689, 16'd16384, 16'd65535, 16'd0};
  logic        ts [NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                           1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  exp_approx_pipe_if #(.NUM_LANES(NL), .IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

  exp_approx_pipe #(
    .NUM_LANES(NL), .IN_WIDTH(IW), .IN_FRAC(8), .OUT_WIDTH(OW),
    .OUT_FRAC(14), .LUT_ADDRESS_WIDTH(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] act,
                              input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endfunction

  // Monitor: compare presented output against the queue head every cycle it
  // is valid (also proves stability while stalled); pop on handshake.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 64'd1, 64'd0);
      end else begin
        mon_it = q[0];
        chk("out_e", bus.out_e, mon_it.e);
        chk("out_sat", 64'(bus.out_sat), 64'(mon_it.sat));
        chk("out_last", 64'(bus.out_last), 64'(mon_it.last));
        if (bus.out_ready) begin
          if (mon_it.cyc >= 0) chk("latency", 64'(cyc), 64'(mon_it.cyc));
          void'(q.pop_front());
        end
      end
    end
  end

  // Drive one beat starting at posedge+1; returns at posedge+1 after accept.
  task automatic send(input int a, input int b, input int c, input int d,
                      input logic last, input logic chk_lat, input logic push);
    int          k [NL];
    logic [63:0] xv;
    exp_t        it;
    bit          acc;
    k = '{a, b, c, d};
    xv = '0;
    it.e = '0;
    it.sat = '0;
    for (int i = 0; i < NL; i++) begin
      xv[i*IW +: IW]   = 16'(tx[k[i]]);
      it.e[i*OW +: OW] = te[k[i]];
      it.sat[i]        = ts[k[i]];
    end
    it.last = last;
    it.cyc  = -1;
    bus.in_valid = 1'b1;
    bus.in_x     = xv;
    bus.in_last  = last;
    acc = 1'b0;
    for (int w = 0; w < 40 && !acc; w++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = 1'b1;
        if (chk_lat) it.cyc = cyc + 3;
        if (push) q.push_back(it);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    for (int w = 0; w < 100 && q.size() != 0; w++) @(negedge clk);
    chk("drain", 64'(q.size()), 64'd0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst    = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_e", bus.out_e, 64'd0);
    chk("rst_out_last", 64'(bus.out_last), 64'd0);
    chk("rst_out_sat", 64'(bus.out_sat), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Each vector alone in lane 0, remaining lanes at x=0.
    for (int v = 0; v < NV; v++) begin
      send(v, 0, 0, 0, 1'b0, 1'b1, 1'b1);
      drain();
    end

    // Mixed lanes {0,-256,256,512}: sat only on lane 3.
    send(0, 1, 2, 3, 1'b0, 1'b1, 1'b1);
    drain();

    // Ten back-to-back beats, row end on the tenth.
    for (int b = 0; b < 10; b++) begin
      send((4*b) % NV, (4*b+1) % NV, (4*b+2) % NV, (4*b+3) % NV,
           (b == 9), 1'b1, 1'b1);
    end
    drain();

    // Stall with three beats in flight.
    send(4, 5, 6, 7, 1'b0, 1'b0, 1'b1);
    send(8, 9, 10, 11, 1'b0, 1'b0, 1'b1);
    bus.out_ready = 1'b0;
    send(12, 13, 0, 1, 1'b1, 1'b0, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();

    // Reset with two beats in flight: neither may emerge.
    send(0, 1, 2, 3, 1'b0, 1'b0, 1'b0);
    send(4, 5, 6, 7, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    send(2, 3, 9, 10, 1'b1, 1'b1, 1'b1);
    drain();

    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
